// File: rtl/fifo_rd_downsizer.sv
// Drains wide words from a show-ahead FIFO read port and replays them as a narrow
// valid/ready stream, RATIO slices per word, with tlast marking every FRAME_WORDS words.
module fifo_rd_downsizer #(
  parameter int OUT_WIDTH   = 8,
  parameter int RATIO       = 4,
  parameter int FIFO_WIDTH  = OUT_WIDTH * RATIO,
  parameter int FRAME_WORDS = 16,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                  rd_clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [FIFO_WIDTH-1:0] fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_o,
  output logic [OUT_WIDTH-1:0]  tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o
);

  localparam int SW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [SW-1:0] SLICE_LAST = SW'(RATIO - 1);
  localparam logic [WW-1:0] WORD_LAST  = WW'(FRAME_WORDS - 1);

  logic [FIFO_WIDTH-1:0] word_reg;
  logic                  word_vld_reg;
  logic [SW-1:0]         slice_cnt_reg;
  logic [WW-1:0]         word_cnt_reg;
  logic [WW-1:0]         word_cnt_next;

  logic [OUT_WIDTH-1:0]  slices [RATIO];
  logic [OUT_WIDTH-1:0]  tdata_mux;
  logic                  accept;
  logic                  last_slice;
  logic                  last_acc;

  // Slice table in emission order, so the output mux only ever indexes by slice_cnt.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    if (MSB_FIRST) begin : g_msb
      assign slices[gi] = word_reg[(RATIO-1-gi)*OUT_WIDTH +: OUT_WIDTH];
    end else begin : g_lsb
      assign slices[gi] = word_reg[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_comb begin
    tdata_mux = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (slice_cnt_reg == SW'(i)) tdata_mux = slices[i];
    end
  end

  assign accept     = word_vld_reg & tready_i;
  assign last_slice = (slice_cnt_reg == SLICE_LAST);
  assign last_acc   = accept & last_slice;

  // Gated by rst_i too, so a held reset never pops the FIFO behind the drain's back.
  assign fifo_rd_o = ~rst_i & ~fifo_empty_i & ~clear_i & (~word_vld_reg | last_acc);

  assign tvalid_o = word_vld_reg;
  assign tdata_o  = tdata_mux;
  assign tlast_o  = word_vld_reg & last_slice & (word_cnt_reg == WORD_LAST);

  always_comb begin
    word_cnt_next = word_cnt_reg;
    if (last_acc) begin
      word_cnt_next = (word_cnt_reg == WORD_LAST) ? '0 : word_cnt_reg + WW'(1);
    end
  end

  always_ff @(posedge rd_clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_reg      <= '0;
      word_vld_reg  <= 1'b0;
      slice_cnt_reg <= '0;
      word_cnt_reg  <= '0;
    end else if (clear_i) begin
      word_vld_reg  <= 1'b0;
      slice_cnt_reg <= '0;
      word_cnt_reg  <= '0;
    end else begin
      if (fifo_rd_o) begin
        // Pop and load on the same edge keeps words back-to-back with no bubble.
        word_reg      <= fifo_data_i;
        word_vld_reg  <= 1'b1;
        slice_cnt_reg <= '0;
      end else if (last_acc) begin
        word_vld_reg  <= 1'b0;
        slice_cnt_reg <= '0;
      end else if (accept) begin
        slice_cnt_reg <= slice_cnt_reg + SW'(1);
      end
      word_cnt_reg <= word_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_rd_downsizer.sv
// Directed bench: a shared array FIFO model feeds an LSB-first and an MSB-first drain.
module tb_fifo_rd_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        tready = 1'b0;
  logic [31:0] fifo_data;
  logic        fifo_empty;
  logic        rd_lsb, rd_msb;
  logic [7:0]  tdata_lsb, tdata_msb;
  logic        tvalid_lsb, tvalid_msb;
  logic        tlast_lsb, tlast_msb;

  logic [31:0] mem [64];
  int          rd_ptr = 0;
  int          wr_ptr = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[5:0]];

  always @(posedge clk) begin
    if (rd_lsb && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  fifo_rd_downsizer #(.OUT_WIDTH(8), .RATIO(4), .FRAME_WORDS(2), .MSB_FIRST(1'b0)) dut_lsb (
    .rd_clk_i(clk), .rst_i(rst), .clear_i(clear), .fifo_data_i(fifo_data),
    .fifo_empty_i(fifo_empty), .fifo_rd_o(rd_lsb), .tdata_o(tdata_lsb),
    .tvalid_o(tvalid_lsb), .tready_i(tready), .tlast_o(tlast_lsb)
  );

  fifo_rd_downsizer #(.OUT_WIDTH(8), .RATIO(4), .FRAME_WORDS(2), .MSB_FIRST(1'b1)) dut_msb (
    .rd_clk_i(clk), .rst_i(rst), .clear_i(clear), .fifo_data_i(fifo_data),
    .fifo_empty_i(fifo_empty), .fifo_rd_o(rd_msb), .tdata_o(tdata_msb),
    .tvalid_o(tvalid_msb), .tready_i(tready), .tlast_o(tlast_msb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic expect_slice(input string tag, input logic [31:0] w, input int s,
                              input logic last, input logic rd);
    logic [7:0] lsb, msb;
    lsb = w[s*8 +: 8];
    msb = w[(3-s)*8 +: 8];
    check({tag, "_vld"}, {31'd0, tvalid_lsb}, 32'd1);
    check({tag, "_vld_m"}, {31'd0, tvalid_msb}, 32'd1);
    check({tag, "_dat"}, {24'd0, tdata_lsb}, {24'd0, lsb});
    check({tag, "_dat_m"}, {24'd0, tdata_msb}, {24'd0, msb});
    check({tag, "_last"}, {31'd0, tlast_lsb}, {31'd0, last});
    check({tag, "_rd"}, {31'd0, rd_lsb}, {31'd0, rd});
    check({tag, "_rd_m"}, {31'd0, rd_msb}, {31'd0, rd});
  endtask

  initial begin
    logic [31:0] wv [4];
    logic [31:0] w;
    logic [15:0] pat;
    int          idx, cyc, k, s;

    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset held with a word waiting in the FIFO.
    push(32'hDDCCBBAA);
    @(negedge clk); @(negedge clk); #1;
    check("rst_vld", {31'd0, tvalid_lsb}, 32'd0);
    check("rst_rd", {31'd0, rd_lsb}, 32'd0);
    check("rst_dat", {24'd0, tdata_lsb}, 32'd0);
    check("rst_dat_m", {24'd0, tdata_msb}, 32'd0);
    check("rst_last", {31'd0, tlast_lsb}, 32'd0);

    // Release: first word popped, then slices in both orders.
    @(negedge clk); rst = 1'b0; tready = 1'b1; #1;
    check("rel_rd", {31'd0, rd_lsb}, 32'd1);
    check("rel_vld", {31'd0, tvalid_lsb}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      expect_slice($sformatf("order_s%0d", i), 32'hDDCCBBAA, i, 1'b0, 1'b0);
    end
    @(negedge clk); #1;
    check("order_idle", {31'd0, tvalid_lsb}, 32'd0);
    check("order_pops", rd_ptr, 32'd1);

    // Back-to-back: three words, twelve slices, pops at the 4th and 8th accept.
    wv[0] = 32'h13121110; wv[1] = 32'h23222120; wv[2] = 32'h33323130;
    @(negedge clk);
    push(wv[0]); push(wv[1]); push(wv[2]);
    #1;
    check("b2b_first_rd", {31'd0, rd_lsb}, 32'd1);
    check("b2b_first_vld", {31'd0, tvalid_lsb}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      w = wv[i/4];
      expect_slice($sformatf("b2b_%0d", i), w, i % 4, (i == 3 || i == 11), (i == 3 || i == 7));
    end
    @(negedge clk); #1;
    check("b2b_idle", {31'd0, tvalid_lsb}, 32'd0);
    check("b2b_pops", rd_ptr, 32'd4);
    check("b2b_empty", {31'd0, fifo_empty}, 32'd1);

    // Backpressure and framing: four words under a fixed tready pattern.
    for (int i = 0; i < 4; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(8'h40 + 4*i + j);
      wv[i] = w;
    end
    pat = 16'b1011_0010_1100_1101;
    @(negedge clk); tready = 1'b0;
    push(wv[0]); push(wv[1]); push(wv[2]); push(wv[3]);
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 300) begin
      @(negedge clk); tready = pat[cyc % 16]; #1;
      if (fifo_empty) check("bp_rd_on_empty", {31'd0, rd_lsb}, 32'd0);
      if (tvalid_lsb) begin
        k = idx / 4; s = idx % 4;
        w = wv[k];
        check($sformatf("bp_dat_%0d", idx), {24'd0, tdata_lsb}, {24'd0, w[s*8 +: 8]});
        check($sformatf("bp_dat_m_%0d", idx), {24'd0, tdata_msb}, {24'd0, w[(3-s)*8 +: 8]});
        check($sformatf("bp_last_%0d", idx), {31'd0, tlast_lsb}, {31'd0, (idx % 8) == 7});
        if (tready) idx++;
      end
      cyc++;
    end
    check("bp_count", idx, 32'd16);
    @(negedge clk); tready = 1'b1; #1;
    check("bp_idle", {31'd0, tvalid_lsb}, 32'd0);
    check("bp_pops", rd_ptr, 32'd8);

    // Clear mid-word: X1 dropped after slice 2, word counter restarts.
    wv[0] = 32'h53525150; wv[1] = 32'h63626160; wv[2] = 32'h73727170; wv[3] = 32'h83828180;
    @(negedge clk);
    push(wv[0]); push(wv[1]); push(wv[2]); push(wv[3]);
    #1;
    check("clr_first_rd", {31'd0, rd_lsb}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      expect_slice($sformatf("clr_x0_%0d", i), wv[0], i, 1'b0, (i == 3));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      expect_slice($sformatf("clr_x1_%0d", i), wv[1], i, 1'b0, 1'b0);
    end
    @(negedge clk); clear = 1'b1; #1;
    expect_slice("clr_x1_2", wv[1], 2, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("clr_vld", {31'd0, tvalid_lsb}, 32'd0);
    check("clr_no_pop", {31'd0, rd_lsb}, 32'd0);
    @(negedge clk); clear = 1'b0; #1;
    check("clr_rel_vld", {31'd0, tvalid_lsb}, 32'd0);
    check("clr_rel_rd", {31'd0, rd_lsb}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      expect_slice($sformatf("clr_x2_%0d", i), wv[2], i, 1'b0, (i == 3));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      expect_slice($sformatf("clr_x3_%0d", i), wv[3], i, (i == 3), 1'b0);
    end
    @(negedge clk); #1;
    check("clr_idle", {31'd0, tvalid_lsb}, 32'd0);
    check("clr_pops", rd_ptr, 32'd12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
